cmac_dot_engine: RTL and testbench

//   Parametrised complex multiply-accumulate dot-product engine. On start it issues LEN read addresses to
//   two complex sample RAMs (A and B) and forms sum(a_k * b_k), or sum(a_k * conj(b_k)) in CONJ mode.
//   It rescales the sum to the output Q format with saturation and pulses done.
//   It is the generalised successor of the fixed 2x2 matrix MAC datapath: width, depth, length and conj mode
//   are configurable, and it has its own address sequencer.

---
 rtl/cmac_pkg.sv | 39 +++
 rtl/cmac_cmul.sv | 94 +++++++++
 rtl/cmac_dot_engine.sv | 188 ++++++++++++++++++
 tb/tb_cmac_dot_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_pkg.sv
// cmac_pkg: shared types and helpers for the complex MAC dot-product engine.
//   cmac_state_e : sequencer states (IDLE, RUN, DRAIN, FLUSH, DONE)
//   PIPE_LAT     : issue-to-accumulate latency of the datapath, in cycles
//   acc_width()  : exact accumulator width for a given sample width and depth
//   clip_dir()   : range test of a rescaled value against an NBIT signed word
package cmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } cmac_state_e;

  // RAM read (1) + product register (1) + combine register (1) + accumulate (1)
  localparam int PIPE_LAT = 4;

  // Working width of clip_dir(); must exceed any accumulator width in use.
  localparam int CLIP_W = 192;

  // Combine term is 2*NBIT+1 bits; summing up to 2**NDIR of them needs NDIR more,
  // plus one spare bit so the sum can never wrap.
  function automatic int acc_width(input int nbit, input int ndir);
    return 2 * nbit + ndir + 2;
  endfunction

  // Returns {above_max, below_min} for a sign-extended, already shifted value
  // compared against the range of an nbit two's complement word.
  function automatic logic [1:0] clip_dir(input logic signed [CLIP_W-1:0] v,
                                          input int nbit);
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    hi = (CLIP_W'(1) << (nbit - 1)) - CLIP_W'(1);
    lo = ~hi;
    return {v > hi, v < lo};
  endfunction

endpackage

// File: rtl/cmac_cmul.sv
// cmac_cmul: two-stage pipelined complex multiplier.
//   Stage P registers the four partial products (full 2*NBIT precision).
//   Stage C registers the real/imag combination (2*NBIT+1 bits), where conj
//   selects a*b or a*conj(b). The valid bit travels alongside the data.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_vld            sample pair on a_*/b_* is a real term
//   conj              0: a*b, 1: a*conj(b); travels with the term
//   a_re,a_im,b_re,b_im  signed NBIT input samples
//   out_vld           c_re/c_im hold a real term this cycle
//   c_re, c_im        combined product, frac bits = 2*FRAC_IN of the inputs
module cmac_cmul #(
  parameter int NBIT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic                  conj,
  input  logic [NBIT-1:0]       a_re,
  input  logic [NBIT-1:0]       a_im,
  input  logic [NBIT-1:0]       b_re,
  input  logic [NBIT-1:0]       b_im,
  output logic                  out_vld,
  output logic signed [2*NBIT:0] c_re,
  output logic signed [2*NBIT:0] c_im
);

  localparam int PW = 2 * NBIT;
  localparam int CW = 2 * NBIT + 1;

  // Sign-extend to product width so a truncated PW x PW multiply is exact.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  assign ar_x = {{NBIT{a_re[NBIT-1]}}, a_re};
  assign ai_x = {{NBIT{a_im[NBIT-1]}}, a_im};
  assign br_x = {{NBIT{b_re[NBIT-1]}}, b_re};
  assign bi_x = {{NBIT{b_im[NBIT-1]}}, b_im};

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic                 p_vld;
  logic                 p_conj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld  <= 1'b0;
      p_conj <= 1'b0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
    end else begin
      p_vld <= in_vld;
      if (in_vld) begin
        p_conj <= conj;
        p_rr   <= ar_x * br_x;
        p_ii   <= ai_x * bi_x;
        p_ri   <= ar_x * bi_x;
        p_ir   <= ai_x * br_x;
      end
    end
  end

  // One guard bit on every partial so sums/differences cannot wrap.
  logic signed [CW-1:0] rr_x, ii_x, ri_x, ir_x;
  logic signed [CW-1:0] re_n, im_n;

  always_comb begin
    rr_x = {p_rr[PW-1], p_rr};
    ii_x = {p_ii[PW-1], p_ii};
    ri_x = {p_ri[PW-1], p_ri};
    ir_x = {p_ir[PW-1], p_ir};
    if (p_conj) begin
      re_n = rr_x + ii_x;
      im_n = ir_x - ri_x;
    end else begin
      re_n = rr_x - ii_x;
      im_n = ri_x + ir_x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      c_re    <= '0;
      c_im    <= '0;
    end else begin
      out_vld <= p_vld;
      if (p_vld) begin
        c_re <= re_n;
        c_im <= im_n;
      end
    end
  end

endmodule

// File: rtl/cmac_dot_engine.sv
// cmac_dot_engine: complex dot product sum(a_k*b_k) or sum(a_k*conj(b_k)) over
// LEN terms read from two synchronous-read sample RAMs, rescaled to the output
// Q format with per-component saturation.
// Handshake: start is a request accepted only in IDLE (busy low); busy rises on
// the accepting edge and stays high through the done cycle; done is a one-cycle
// pulse after which out_re/out_im/sat hold until the next accepted start.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a run (ignored while busy)
//   conj, base_a, base_b, len   run configuration, captured on the start edge
//   rd_en, addr_a, addr_b       registered RAM read strobe and addresses
//   a_re, a_im, b_re, b_im      RAM read data, valid one cycle after rd_en
//   busy, done          run in progress / result valid pulse
//   out_re, out_im, sat result and clip flag
//   dbg_state           current sequencer state
module cmac_dot_engine
  import cmac_pkg::*;
#(
  parameter int NBIT     = 32,
  parameter int FRAC_IN  = 27,
  parameter int FRAC_OUT = 21,
  parameter int NDIR     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              conj,
  input  logic [NDIR-1:0]   base_a,
  input  logic [NDIR-1:0]   base_b,
  input  logic [NDIR:0]     len,
  output logic              rd_en,
  output logic [NDIR-1:0]   addr_a,
  output logic [NDIR-1:0]   addr_b,
  input  logic [NBIT-1:0]   a_re,
  input  logic [NBIT-1:0]   a_im,
  input  logic [NBIT-1:0]   b_re,
  input  logic [NBIT-1:0]   b_im,
  output logic              busy,
  output logic              done,
  output logic [NBIT-1:0]   out_re,
  output logic [NBIT-1:0]   out_im,
  output logic              sat,
  output cmac_state_e       dbg_state
);

  localparam int ACCW = acc_width(NBIT, NDIR);
  localparam int CW   = 2 * NBIT + 1;
  localparam int SH   = 2 * FRAC_IN - FRAC_OUT;

  cmac_state_e          state;
  logic                 conj_r;
  logic [NDIR:0]        len_r;
  logic [NDIR:0]        issue_cnt;
  logic [1:0]           drain_cnt;
  logic                 ram_vld;
  logic signed [ACCW-1:0] acc_re, acc_im;

  logic                 c_vld;
  logic signed [CW-1:0] c_re, c_im;

  assign dbg_state = state;

  // RAM data lags the read strobe by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_vld <= 1'b0;
    else     ram_vld <= rd_en;
  end

  cmac_cmul #(.NBIT(NBIT)) u_cmul (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (ram_vld),
    .conj    (conj_r),
    .a_re    (a_re),
    .a_im    (a_im),
    .b_re    (b_re),
    .b_im    (b_im),
    .out_vld (c_vld),
    .c_re    (c_re),
    .c_im    (c_im)
  );

  // Rescale (floor via arithmetic shift) and saturate each component.
  logic signed [ACCW-1:0] sh_re, sh_im;
  logic [1:0]             dir_re, dir_im;
  logic [NBIT-1:0]        res_re, res_im;
  logic                   res_sat;

  localparam logic [NBIT-1:0] OUT_MAX = {1'b0, {(NBIT-1){1'b1}}};
  localparam logic [NBIT-1:0] OUT_MIN = {1'b1, {(NBIT-1){1'b0}}};

  always_comb begin
    sh_re  = acc_re >>> SH;
    sh_im  = acc_im >>> SH;
    dir_re = clip_dir({{(CLIP_W-ACCW){sh_re[ACCW-1]}}, sh_re}, NBIT);
    dir_im = clip_dir({{(CLIP_W-ACCW){sh_im[ACCW-1]}}, sh_im}, NBIT);
    res_re = dir_re[1] ? OUT_MAX : (dir_re[0] ? OUT_MIN : sh_re[NBIT-1:0]);
    res_im = dir_im[1] ? OUT_MAX : (dir_im[0] ? OUT_MIN : sh_im[NBIT-1:0]);
    res_sat = (|dir_re) | (|dir_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      conj_r    <= 1'b0;
      len_r     <= '0;
      issue_cnt <= '0;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      sat       <= 1'b0;
      acc_re    <= '0;
      acc_im    <= '0;
    end else begin
      done <= 1'b0;

      // The pipeline is empty whenever a start is accepted, so the clear
      // never competes with a pending accumulate.
      if (state == ST_IDLE && start) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (c_vld) begin
        acc_re <= acc_re + {{(ACCW-CW){c_re[CW-1]}}, c_re};
        acc_im <= acc_im + {{(ACCW-CW){c_im[CW-1]}}, c_im};
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            conj_r <= conj;
            len_r  <= len;
            busy   <= 1'b1;
            addr_a <= base_a;
            addr_b <= base_b;
            if (len != '0) begin
              rd_en     <= 1'b1;
              issue_cnt <= (NDIR+1)'(1);
              state     <= ST_RUN;
            end else begin
              state <= ST_FLUSH;
            end
          end
        end

        // issue_cnt counts reads already on the bus; addresses wrap mod 2**NDIR.
        ST_RUN: begin
          if (issue_cnt == len_r) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            addr_a    <= addr_a + NDIR'(1);
            addr_b    <= addr_b + NDIR'(1);
            issue_cnt <= issue_cnt + (NDIR+1)'(1);
          end
        end

        // The last term reaches the accumulator PIPE_LAT-1 edges after the
        // strobe drops; leave on that edge so FLUSH sees the final sum.
        ST_DRAIN: begin
          if (drain_cnt == 2'(PIPE_LAT - 2)) state <= ST_FLUSH;
          else drain_cnt <= drain_cnt + 2'd1;
        end

        ST_FLUSH: begin
          out_re <= res_re;
          out_im <= res_im;
          sat    <= res_sat;
          done   <= 1'b1;
          state  <= ST_DONE;
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_dot_engine.sv
module tb_cmac_dot_engine;
  import cmac_pkg::*;

  localparam int NBIT = 32;
  localparam int NDIR = 4;
  localparam int SH   = 2 * 27 - 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              conj = 1'b0;
  logic [NDIR-1:0]   base_a = '0, base_b = '0;
  logic [NDIR:0]     len = '0;
  logic              rd_en;
  logic [NDIR-1:0]   addr_a, addr_b;
  logic [NBIT-1:0]   a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic              busy, done, sat;
  logic [NBIT-1:0]   out_re, out_im;
  cmac_state_e       dbg_state;

  cmac_dot_engine dut (
    .clk(clk), .rst(rst), .start(start), .conj(conj),
    .base_a(base_a), .base_b(base_b), .len(len),
    .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .busy(busy), .done(done), .out_re(out_re), .out_im(out_im),
    .sat(sat), .dbg_state(dbg_state)
  );

  // Synchronous-read sample RAMs.
  logic signed [NBIT-1:0] mem_a_re [16], mem_a_im [16], mem_b_re [16], mem_b_im [16];
  always @(posedge clk) begin
    if (rd_en) begin
      a_re <= mem_a_re[addr_a];
      a_im <= mem_a_im[addr_a];
      b_re <= mem_b_re[addr_b];
      b_im <= mem_b_im[addr_b];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Observations from the last run_dot call.
  int              obs_done_j, obs_done_cnt, obs_rd_cnt, obs_busy_cnt;
  logic [NDIR-1:0] obs_addr_a[$], obs_addr_b[$];
  logic [NBIT-1:0] exp_q[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic fill_const(input logic [31:0] ar, ai, br, bi);
    for (int i = 0; i < 16; i++) begin
      mem_a_re[i] = ar; mem_a_im[i] = ai; mem_b_re[i] = br; mem_b_im[i] = bi;
    end
  endtask

  // Starts a run and watches a bounded window; j counts cycles after E0
  // (j = n means the cycle following edge En). Configuration inputs are
  // scrambled right after E0 so late changes would corrupt a faulty capture.
  task automatic run_dot(input logic c, input logic [NDIR-1:0] ba, input logic [NDIR-1:0] bb,
                         input logic [NDIR:0] ln, input bit poke);
    obs_done_j = -1; obs_done_cnt = 0; obs_rd_cnt = 0; obs_busy_cnt = 0;
    obs_addr_a.delete(); obs_addr_b.delete();
    @(negedge clk);
    conj = c; base_a = ba; base_b = bb; len = ln; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; conj = ~c; base_a = ~ba; base_b = ~bb; len = '0;
    for (int j = 0; j < int'(ln) + 12; j++) begin
      if (rd_en) begin
        obs_rd_cnt++;
        obs_addr_a.push_back(addr_a);
        obs_addr_b.push_back(addr_b);
      end
      if (busy) obs_busy_cnt++;
      if (done) begin
        if (obs_done_cnt == 0) obs_done_j = j;
        obs_done_cnt++;
      end
      start = poke && (j == 2 || j == int'(ln) + 4);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Reference model: exact wide sum, floor shift, saturate.
  task automatic model(input logic c, input logic [NDIR-1:0] ba, input logic [NDIR-1:0] bb,
                       input logic [NDIR:0] ln,
                       output logic [31:0] e_re, output logic [31:0] e_im, output logic e_sat);
    logic signed [127:0] sr, si, ar, ai, br, bi, hi, lo;
    logic [NDIR-1:0] ia, ib;
    sr = 0; si = 0; e_sat = 1'b0;
    hi = 128'sh7FFF_FFFF; lo = -128'sh8000_0000;
    for (int k = 0; k < int'(ln); k++) begin
      ia = ba + NDIR'(k); ib = bb + NDIR'(k);
      ar = mem_a_re[ia]; ai = mem_a_im[ia]; br = mem_b_re[ib]; bi = mem_b_im[ib];
      if (c) begin
        sr = sr + ar * br + ai * bi;
        si = si + ai * br - ar * bi;
      end else begin
        sr = sr + ar * br - ai * bi;
        si = si + ar * bi + ai * br;
      end
    end
    sr = sr >>> SH; si = si >>> SH;
    if (sr > hi) begin sr = hi; e_sat = 1'b1; end
    if (sr < lo) begin sr = lo; e_sat = 1'b1; end
    if (si > hi) begin si = hi; e_sat = 1'b1; end
    if (si < lo) begin si = lo; e_sat = 1'b1; end
    e_re = sr[31:0]; e_im = si[31:0];
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({rd_en, busy, done, sat} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", {rd_en, busy, done, sat}); end
    n_vec++; if ({out_re, out_im} !== 64'h0) begin n_err++;
      $display("FAIL reset_out: got %h %h want 0 0", out_re, out_im); end
    n_vec++; if ({addr_a, addr_b} !== 8'h0) begin n_err++;
      $display("FAIL reset_addr: got %h %h want 0 0", addr_a, addr_b); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    fill_const(32'h0, 32'h0, 32'h0, 32'h0);
    mem_a_re[0] = 32'h0800_0000; mem_b_im[0] = 32'h0800_0000;
    run_dot(1'b0, 4'd0, 4'd0, 5'd1, 1'b0);
    n_vec++; if (out_re !== 32'h0) begin n_err++;
      $display("FAIL single_re: got %h want 00000000", out_re); end
    n_vec++; if (out_im !== 32'h0020_0000) begin n_err++;
      $display("FAIL single_im: got %h want 00200000", out_im); end
    n_vec++; if (sat !== 1'b0) begin n_err++;
      $display("FAIL single_sat: got %b want 0", sat); end
    n_vec++; if (obs_done_j != 5 || obs_done_cnt != 1) begin n_err++;
      $display("FAIL single_done: got cycle %0d count %0d want 5 1", obs_done_j, obs_done_cnt); end
    n_vec++; if (obs_busy_cnt != 6) begin n_err++;
      $display("FAIL single_busy: got %0d cycles want 6", obs_busy_cnt); end
  endtask

  task automatic test_len4_conj();
    fill_const(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'hF800_0000);
    run_dot(1'b0, 4'd5, 4'd9, 5'd4, 1'b0);
    n_vec++; if ({out_re, out_im, sat} !== {32'h0100_0000, 32'h0, 1'b0}) begin n_err++;
      $display("FAIL len4_plain: got %h %h %b want 01000000 00000000 0", out_re, out_im, sat); end
    n_vec++; if (obs_done_j != 8) begin n_err++;
      $display("FAIL len4_done: got cycle %0d want 8", obs_done_j); end
    run_dot(1'b1, 4'd5, 4'd9, 5'd4, 1'b0);
    n_vec++; if ({out_re, out_im, sat} !== {32'h0, 32'h0100_0000, 1'b0}) begin n_err++;
      $display("FAIL len4_conj: got %h %h %b want 00000000 01000000 0", out_re, out_im, sat); end
  endtask

  task automatic test_saturate();
    fill_const(32'h7800_0000, 32'h0, 32'h7800_0000, 32'h0);
    run_dot(1'b0, 4'd0, 4'd0, 5'd16, 1'b0);
    n_vec++; if ({out_re, out_im, sat} !== {32'h7FFF_FFFF, 32'h0, 1'b1}) begin n_err++;
      $display("FAIL sat_pos: got %h %h %b want 7fffffff 00000000 1", out_re, out_im, sat); end
    n_vec++; if (obs_done_j != 20 || obs_rd_cnt != 16) begin n_err++;
      $display("FAIL sat_timing: got done %0d reads %0d want 20 16", obs_done_j, obs_rd_cnt); end
    fill_const(32'h7800_0000, 32'h0, 32'h8800_0000, 32'h0);
    run_dot(1'b0, 4'd7, 4'd2, 5'd16, 1'b0);
    n_vec++; if ({out_re, out_im, sat} !== {32'h8000_0000, 32'h0, 1'b1}) begin n_err++;
      $display("FAIL sat_neg: got %h %h %b want 80000000 00000000 1", out_re, out_im, sat); end
  endtask

  task automatic test_len0();
    run_dot(1'b0, 4'd0, 4'd0, 5'd0, 1'b0);
    n_vec++; if ({out_re, out_im, sat} !== 65'h0) begin n_err++;
      $display("FAIL len0_out: got %h %h %b want 0 0 0", out_re, out_im, sat); end
    n_vec++; if (obs_done_j != 1 || obs_rd_cnt != 0 || obs_busy_cnt != 2) begin n_err++;
      $display("FAIL len0_timing: got done %0d reads %0d busy %0d want 1 0 2",
               obs_done_j, obs_rd_cnt, obs_busy_cnt); end
  endtask

  task automatic test_addr_wrap();
    logic [NDIR-1:0] ea [4];
    logic [NDIR-1:0] eb [4];
    ea = '{4'd14, 4'd15, 4'd0, 4'd1};
    eb = '{4'd3, 4'd4, 4'd5, 4'd6};
    run_dot(1'b0, 4'd14, 4'd3, 5'd4, 1'b0);
    n_vec++; if (obs_rd_cnt != 4) begin n_err++;
      $display("FAIL addr_rd_cycles: got %0d want 4", obs_rd_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (obs_addr_a.size() == 0 || obs_addr_b.size() == 0) begin n_err++;
        $display("FAIL addr_seq[%0d]: got no read want %0d/%0d", k, ea[k], eb[k]);
      end else begin
        logic [NDIR-1:0] ga, gb;
        ga = obs_addr_a.pop_front(); gb = obs_addr_b.pop_front();
        if (ga !== ea[k] || gb !== eb[k]) begin n_err++;
          $display("FAIL addr_seq[%0d]: got %0d/%0d want %0d/%0d", k, ga, gb, ea[k], eb[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_const(32'h0800_0000, 32'h0, 32'h1000_0000, 32'h0);
    run_dot(1'b0, 4'd0, 4'd0, 5'd2, 1'b1);
    n_vec++; if (obs_done_cnt != 1 || obs_done_j != 6) begin n_err++;
      $display("FAIL busy_start_done: got count %0d cycle %0d want 1 6", obs_done_cnt, obs_done_j); end
    n_vec++; if (obs_busy_cnt != 7 || obs_rd_cnt != 2) begin n_err++;
      $display("FAIL busy_start_busy: got busy %0d reads %0d want 7 2", obs_busy_cnt, obs_rd_cnt); end
    n_vec++; if ({out_re, out_im} !== {32'h0080_0000, 32'h0}) begin n_err++;
      $display("FAIL busy_start_out: got %h %h want 00800000 00000000", out_re, out_im); end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    fill_const(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0);
    @(negedge clk);
    len = 5'd8; base_a = 4'd0; base_b = 4'd0; conj = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({rd_en, busy, done, sat} !== 4'b0 || {out_re, out_im} !== 64'h0) begin n_err++;
      $display("FAIL rst_mid_out: got flags %b out %h %h want 0000 0 0",
               {rd_en, busy, done, sat}, out_re, out_im); end
    n_vec++; if (dbg_state !== ST_IDLE || {addr_a, addr_b} !== 8'h0) begin n_err++;
      $display("FAIL rst_mid_state: got %0d addr %h %h want %0d 0 0", dbg_state, addr_a, addr_b, ST_IDLE); end
    rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_vec++; if (dcnt != 0) begin n_err++;
      $display("FAIL rst_mid_nodone: got %0d busy/done cycles want 0", dcnt); end
  endtask

  task automatic test_random();
    logic [31:0] e_re, e_im, g;
    logic e_sat, c;
    logic [NDIR-1:0] ba, bb;
    logic [NDIR:0] ln;
    int sh;
    for (int r = 0; r < 1000; r++) begin
      case ($urandom_range(0, 3))
        0: sh = 0;
        1: sh = 3;
        2: sh = 8;
        default: sh = 14;
      endcase
      for (int i = 0; i < 16; i++) begin
        mem_a_re[i] = $signed($urandom) >>> sh; mem_a_im[i] = $signed($urandom) >>> sh;
        mem_b_re[i] = $signed($urandom) >>> sh; mem_b_im[i] = $signed($urandom) >>> sh;
      end
      c = 1'($urandom_range(0, 1));
      ba = NDIR'($urandom_range(0, 15));
      bb = NDIR'($urandom_range(0, 15));
      ln = (NDIR+1)'($urandom_range(0, 16));
      model(c, ba, bb, ln, e_re, e_im, e_sat);
      exp_q.push_back(e_re);
      exp_q.push_back(e_im);
      exp_q.push_back({31'b0, e_sat});
      run_dot(c, ba, bb, ln, 1'b0);
      g = exp_q.pop_front();
      n_vec++; if (out_re !== g) begin n_err++;
        $display("FAIL rand_re[%0d]: got %h want %h", r, out_re, g); end
      g = exp_q.pop_front();
      n_vec++; if (out_im !== g) begin n_err++;
        $display("FAIL rand_im[%0d]: got %h want %h", r, out_im, g); end
      g = exp_q.pop_front();
      n_vec++; if ({31'b0, sat} !== g) begin n_err++;
        $display("FAIL rand_sat[%0d]: got %b want %b", r, sat, g[0]); end
      n_vec++; if (obs_done_j != ((ln == 0) ? 1 : int'(ln) + 4) || obs_done_cnt != 1) begin n_err++;
        $display("FAIL rand_done[%0d]: got cycle %0d count %0d len %0d", r, obs_done_j, obs_done_cnt, ln); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fill_const(32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_single();
    test_len4_conj();
    test_saturate();
    test_len0();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
